// File: rtl/noc_router_mc_buffered.sv
`default_nettype none
// ============================================================================
// Module      : noc_router_mc_buffered
// Description : Buffered multicast NoC router. Each input port feeds a FIFO.
//               A round-robin arbiter grants one head flit per cycle. The
//               granted flit is copied atomically into every output register
//               enabled by the destination mask. All flow control uses
//               valid/ready handshakes.
//               Optional statistics counters: define NOC_ROUTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_router_mc_buffered #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_we_i,
    input  logic [NUM_PORTS-1:0]            cfg_mask_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_PORTS-1:0]            in_valid_i,
    output logic [NUM_PORTS-1:0]            in_ready_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_o,
    output logic [NUM_PORTS-1:0]            out_valid_o,
    input  logic [NUM_PORTS-1:0]            out_ready_i,
    output logic [NUM_PORTS-1:0]            grant_o
`ifdef NOC_ROUTER_STATS_EN
    ,
    output logic [31:0]                     stat_grant_cnt_o,
    output logic [31:0]                     stat_stall_cnt_o
`endif
);

    localparam int                   c_AW       = $clog2(FIFO_DEPTH);
    localparam int                   c_PW       = $clog2(NUM_PORTS);
    localparam logic [c_PW-1:0]      c_LAST     = c_PW'(NUM_PORTS - 1);
    localparam logic [c_PW:0]        c_NPORTS   = (c_PW + 1)'(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] c_ONE_HOT0 = NUM_PORTS'(1);

    // ------------------------------------------------------------------------
    // Shared state and wires
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0]            r_mask;
    logic [c_PW-1:0]                 r_rr_ptr;
    logic [NUM_PORTS-1:0]            r_out_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_out_data;

    logic [NUM_PORTS-1:0]            w_nonempty;
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_head;
    logic [NUM_PORTS-1:0]            w_out_free;
    logic                            w_can_issue;
    logic                            w_found;
    logic [c_PW-1:0]                 w_sel;
    logic [c_PW:0]                   w_idx;
    logic                            w_grant_any;
    logic [DATA_WIDTH-1:0]           w_grant_data;

    // ------------------------------------------------------------------------
    // Per-input FIFOs. Ready depends only on stored occupancy, so a pop in
    // the same cycle never opens a slot for a push into a full FIFO.
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [c_AW:0]         r_wr_ptr;
        logic [c_AW:0]         r_rd_ptr;
        logic                  w_full;
        logic                  w_push;
        logic                  w_pop;

        assign w_full = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
        assign w_push = in_valid_i[p] && !w_full;
        assign w_pop  = grant_o[p];

        assign in_ready_o[p] = !w_full;
        assign w_nonempty[p] = (r_wr_ptr != r_rd_ptr);
        assign w_head[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr[c_AW-1:0]];

        // Pointer update; reset empties the FIFO and discards its contents
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end

        // Storage write; contents need no reset because the pointers gate them
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= in_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    assign w_out_free   = ~r_out_valid | out_ready_i;
    // Every masked destination must be free, otherwise nothing is sent at all
    assign w_can_issue  = &(w_out_free | ~r_mask);
    assign w_grant_any  = w_found && w_can_issue;
    assign w_grant_data = w_head[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign grant_o      = w_grant_any ? (c_ONE_HOT0 << w_sel) : '0;

    // Round-robin search for the first non-empty FIFO starting at the pointer
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_PW + 1)'(i);
            if (w_idx >= c_NPORTS) w_idx = w_idx - c_NPORTS;
            if (!w_found && w_nonempty[w_idx[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_PW-1:0];
            end
        end
    end

    // Pointer moves past the granted port and holds when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= (w_sel == c_LAST) ? '0 : w_sel + c_PW'(1);
        end
    end

    // Destination mask; a new value governs arbitration from the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (cfg_we_i) begin
            r_mask <= cfg_mask_i;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: load on a multicast, otherwise retire on handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant_any && r_mask[p]) begin
                    r_out_valid[p]                          <= 1'b1;
                    r_out_data[p*DATA_WIDTH +: DATA_WIDTH]  <= w_grant_data;
                end else if (out_ready_i[p]) begin
                    r_out_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

`ifdef NOC_ROUTER_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------------
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (|w_nonempty) && !w_grant_any;

    // Count grants and blocked cycles with pending work, saturating at all ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_any && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1))     r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stat_grant_cnt_o = r_grant_cnt;
    assign stat_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_router_mc_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_router_mc_buffered
// Description : Scoreboard bench for noc_router_mc_buffered. A queue-based
//               reference model predicts grants, readiness and the flits each
//               output must deliver; a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_router_mc_buffered;

    localparam int DW = 16;
    localparam int NP = 4;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we_i;
    logic [NP-1:0]     cfg_mask_i;
    logic [NP*DW-1:0]  in_data_i;
    logic [NP-1:0]     in_valid_i;
    logic [NP-1:0]     in_ready_o;
    logic [NP*DW-1:0]  out_data_o;
    logic [NP-1:0]     out_valid_o;
    logic [NP-1:0]     out_ready_i;
    logic [NP-1:0]     grant_o;
`ifdef NOC_ROUTER_STATS_EN
    logic [31:0]       stat_grant_cnt_o;
    logic [31:0]       stat_stall_cnt_o;
`endif

    always #5 clk = ~clk;

    noc_router_mc_buffered #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we_i    (cfg_we_i),
        .cfg_mask_i  (cfg_mask_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o)
`ifdef NOC_ROUTER_STATS_EN
        ,
        .stat_grant_cnt_o (stat_grant_cnt_o),
        .stat_stall_cnt_o (stat_stall_cnt_o)
`endif
    );

    // ---------------- reference model state ----------------
    logic [DW-1:0] m_in_q  [NP][$];   // flits waiting at each input
    logic [DW-1:0] m_exp_q [NP][$];   // flits each output still owes
    bit            m_busy  [NP];      // output holds an undelivered flit
    int            m_rr;
    logic [NP-1:0] m_mask;
    logic [NP-1:0] m_acc;
    longint        m_gcnt, m_scnt;

    // expectations for the current cycle, read by the monitor
    logic [NP-1:0] exp_grant, exp_ready, exp_valid;
    logic [31:0]   exp_gcnt, exp_scnt;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // upstream offers (held until accepted)
    logic [NP-1:0] off_v;
    logic [DW-1:0] off_d [NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One cycle of the router's rules, applied to the current inputs
    task automatic model_step();
        logic [NP-1:0] free;
        bit            can, found;
        int            sel;
        logic [DW-1:0] d;
        sel = 0;
        for (int p = 0; p < NP; p++) begin
            exp_ready[p] = (m_in_q[p].size() < FD);
            exp_valid[p] = m_busy[p];
            free[p]      = !m_busy[p] || out_ready_i[p];
        end
        can = 1'b1;
        for (int p = 0; p < NP; p++) if (m_mask[p] && !free[p]) can = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NP; i++) begin
            int idx;
            idx = (m_rr + i) % NP;
            if (!found && m_in_q[idx].size() > 0) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        exp_grant = '0;
        if (found && can) exp_grant[sel] = 1'b1;
        exp_gcnt = 32'(m_gcnt);
        exp_scnt = 32'(m_scnt);
        m_acc    = in_valid_i & exp_ready;

        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                m_in_q[p].delete();
                m_exp_q[p].delete();
                m_busy[p] = 1'b0;
            end
            m_mask = '1;
            m_rr   = 0;
            m_gcnt = 0;
            m_scnt = 0;
            return;
        end

        if (exp_grant != 0) begin
            d = m_in_q[sel].pop_front();
            m_rr = (sel + 1) % NP;
            m_gcnt++;
        end else if (found) begin
            m_scnt++;
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_grant != 0 && m_mask[p]) begin
                m_exp_q[p].push_back(d);
                m_busy[p] = 1'b1;
            end else if (out_ready_i[p]) begin
                m_busy[p] = 1'b0;
            end
            if (m_acc[p]) m_in_q[p].push_back(in_data_i[p*DW +: DW]);
        end
        if (cfg_we_i) m_mask = cfg_mask_i;
    endtask

    // Monitor: compare combinational state and every output handshake
    always @(negedge clk) begin
        if (chk_en) begin
            check("grant_o", 32'(grant_o), 32'(exp_grant));
            check("in_ready_o", 32'(in_ready_o), 32'(exp_ready));
            check("out_valid_o", 32'(out_valid_o), 32'(exp_valid));
`ifdef NOC_ROUTER_STATS_EN
            check("stat_grant_cnt", stat_grant_cnt_o, exp_gcnt);
            check("stat_stall_cnt", stat_stall_cnt_o, exp_scnt);
`endif
            for (int p = 0; p < NP; p++) begin
                if (out_valid_o[p] && out_ready_i[p]) begin
                    if (m_exp_q[p].size() == 0) begin
                        check("out_unexpected", 32'(p), 32'hFFFF_FFFF);
                    end else begin
                        check("out_data", 32'(out_data_o[p*DW +: DW]), 32'(m_exp_q[p].pop_front()));
                    end
                end
            end
        end
    end

    // Drive current offers for one cycle; inputs change at posedge+1
    task automatic tick();
        in_valid_i = off_v;
        for (int p = 0; p < NP; p++) in_data_i[p*DW +: DW] = off_d[p];
        if (!rst_n) out_ready_i = '0;
        #1 model_step();
        @(posedge clk);
        #1;
        off_v    = off_v & ~m_acc;
        cfg_we_i = 1'b0;
        if (!rst_n) off_v = '0;
    endtask

    task automatic offer(input int p, input logic [DW-1:0] d);
        off_v[p] = 1'b1;
        off_d[p] = d;
    endtask

    task automatic wait_accept(input int p);
        int n;
        n = 0;
        while (off_v[p] && n < 40) begin
            tick();
            n++;
        end
        if (off_v[p]) check("push_timeout", 32'(off_v[p]), 32'd0);
    endtask

    task automatic set_mask(input logic [NP-1:0] m);
        cfg_we_i   = 1'b1;
        cfg_mask_i = m;
        tick();
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int p = 0; p < NP; p++) s += m_in_q[p].size() + m_exp_q[p].size();
        return s;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        out_ready_i = '1;
        off_v       = '0;
        while (pending() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_left", 32'(pending()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we_i   = 1'b0;
        cfg_mask_i = '0;
        in_data_i  = '0;
        in_valid_i = '0;
        out_ready_i = '0;
        off_v      = '0;
        for (int p = 0; p < NP; p++) off_d[p] = '0;
        m_mask = '1;
        m_rr   = 0;
        m_gcnt = 0;
        m_scnt = 0;
        for (int p = 0; p < NP; p++) m_busy[p] = 1'b0;
        #1;
        tick();
        tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("reset_out_data", 32'(out_data_o == '0), 32'd1);

        // Broadcast of a single flit with every output ready
        out_ready_i = '1;
        offer(0, 16'hA5A5);
        tick();
        tick();
        check("bcast_valid", 32'(out_valid_o), 32'hF);
        check("bcast_data", 32'(out_data_o[3*DW +: DW]), 32'hA5A5);
        repeat (3) tick();

        // All four inputs contend for the east output
        set_mask(4'b1000);
        for (int p = 0; p < NP; p++) offer(p, 16'((p + 1) << 12));
        repeat (8) tick();

        // Atomic multicast held back by a stalled output
        set_mask(4'b0101);
        out_ready_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            offer(1, 16'h3100 + 16'(k));
            wait_accept(1);
        end
        repeat (4) tick();
        check("stall_in_ready1", 32'(in_ready_o[1]), 32'd0);
        drain();

        // Empty mask drops the flit
        set_mask(4'b0000);
        offer(3, 16'hBEEF);
        repeat (4) tick();

        // Reset in the middle of a stream restores broadcast
        set_mask(4'b0010);
        out_ready_i = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            offer(2, 16'h2200 + 16'(k));
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready_o), 32'hF);
        check("rst_out_valid", 32'(out_valid_o), 32'h0);
        out_ready_i = '1;
        offer(0, 16'h0001);
        repeat (4) tick();

        // Randomised traffic, configuration changes and occasional resets
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < NP; p++)
                if (!off_v[p] && ($urandom_range(2) == 0)) offer(p, 16'($urandom));
            out_ready_i = 4'($urandom) | 4'($urandom);
            if ($urandom_range(39) == 0) begin
                cfg_we_i   = 1'b1;
                cfg_mask_i = 4'($urandom);
            end
            rst_n = ($urandom_range(299) != 0);
            tick();
            rst_n = 1'b1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
